// File: rtl/anton_neopixel_bus_arbiter.sv
// Round-robin arbiter sharing the neopixel register/pixel bus between master A (CPU bridge)
// and master B (fill engine), with optional hold-off of pixel writes while a frame streams.
//
// state   | meaning
// IDLE    | pick an eligible master, drive busAddr/busDataIn and the strobe for next cycle
// STROBE  | busWrite/busRead high for this cycle only, ack registered for next cycle
// CAPTURE | ack pulse to the granted master, read data passed through, rrPtr advances

`ifndef BUFFER_END_DEFAULT
`define BUFFER_END_DEFAULT 14'h1FFF
`endif

module anton_neopixel_bus_arbiter #(
  parameter logic [13:0] BUFFER_END = `BUFFER_END_DEFAULT,
  parameter bit          PIXEL_HOLD = 1'b1
) (
  input  logic        busClk,
  input  logic        busResetn,
  input  logic        reqA,
  input  logic [13:0] addrA,
  input  logic [7:0]  dataA,
  input  logic        writeA,
  input  logic        readA,
  output logic        ackA,
  output logic [7:0]  rdataA,
  input  logic        reqB,
  input  logic [13:0] addrB,
  input  logic [7:0]  dataB,
  input  logic        writeB,
  input  logic        readB,
  output logic        ackB,
  output logic [7:0]  rdataB,
  input  logic        neoState,
  output logic [13:0] busAddr,
  output logic [7:0]  busDataIn,
  output logic        busWrite,
  output logic        busRead,
  input  logic [7:0]  busDataOut
);

  typedef enum logic [1:0] {IDLE, STROBE, CAPTURE} state_t;

  state_t      state;
  logic        rr_ptr;
  logic        gnt;
  logic        gnt_read;
  logic [7:0]  rdata_a_q;
  logic [7:0]  rdata_b_q;

  logic        hold_a;
  logic        hold_b;
  logic        elig_a;
  logic        elig_b;
  logic        pick_b;
  logic        sel_write;
  logic        sel_read;
  logic [7:0]  cap_data;

  assign hold_a = PIXEL_HOLD && neoState && writeA && (addrA <= BUFFER_END);
  assign hold_b = PIXEL_HOLD && neoState && writeB && (addrB <= BUFFER_END);
  assign elig_a = reqA && !hold_a;
  assign elig_b = reqB && !hold_b;
  assign pick_b = elig_b && (!elig_a || rr_ptr);

  assign sel_write = pick_b ? writeB : writeA;
  assign sel_read  = pick_b ? readB  : readA;

  // The bus returns read data in the cycle after busRead, which is the ack cycle,
  // so it is passed straight through while acking and latched for afterwards.
  assign cap_data = gnt_read ? busDataOut : 8'h00;
  assign rdataA   = ackA ? cap_data : rdata_a_q;
  assign rdataB   = ackB ? cap_data : rdata_b_q;

  always_ff @(posedge busClk) begin
    if (!busResetn) begin
      state     <= IDLE;
      rr_ptr    <= 1'b0;
      gnt       <= 1'b0;
      gnt_read  <= 1'b0;
      busAddr   <= '0;
      busDataIn <= '0;
      busWrite  <= 1'b0;
      busRead   <= 1'b0;
      ackA      <= 1'b0;
      ackB      <= 1'b0;
      rdata_a_q <= '0;
      rdata_b_q <= '0;
    end else begin
      busWrite <= 1'b0;
      busRead  <= 1'b0;
      ackA     <= 1'b0;
      ackB     <= 1'b0;
      case (state)
        IDLE: begin
          if (elig_a || elig_b) begin
            gnt       <= pick_b;
            busAddr   <= pick_b ? addrB : addrA;
            busDataIn <= pick_b ? dataB : dataA;
            busWrite  <= sel_write;
            busRead   <= sel_read && !sel_write;
            gnt_read  <= sel_read && !sel_write;
            state     <= STROBE;
          end
        end
        STROBE: begin
          ackA  <= !gnt;
          ackB  <= gnt;
          state <= CAPTURE;
        end
        CAPTURE: begin
          if (gnt) rdata_b_q <= cap_data;
          else     rdata_a_q <= cap_data;
          rr_ptr <= !gnt;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_anton_neopixel_bus_arbiter.sv
// Directed bench for anton_neopixel_bus_arbiter: stimulus queues expected acks per master,
// a negedge monitor pops and checks them against the observed strobe and ack.

module tb_anton_neopixel_bus_arbiter;

  logic        busClk;
  logic        busResetn;
  logic        reqA, writeA, readA, ackA;
  logic [13:0] addrA;
  logic [7:0]  dataA, rdataA;
  logic        reqB, writeB, readB, ackB;
  logic [13:0] addrB;
  logic [7:0]  dataB, rdataB;
  logic        neoState;
  logic [13:0] busAddr;
  logic [7:0]  busDataIn, busDataOut;
  logic        busWrite, busRead;

  anton_neopixel_bus_arbiter dut (
    .busClk(busClk), .busResetn(busResetn),
    .reqA(reqA), .addrA(addrA), .dataA(dataA), .writeA(writeA), .readA(readA),
    .ackA(ackA), .rdataA(rdataA),
    .reqB(reqB), .addrB(addrB), .dataB(dataB), .writeB(writeB), .readB(readB),
    .ackB(ackB), .rdataB(rdataB),
    .neoState(neoState),
    .busAddr(busAddr), .busDataIn(busDataIn), .busWrite(busWrite), .busRead(busRead),
    .busDataOut(busDataOut)
  );

  initial busClk = 1'b0;
  always #5 busClk = ~busClk;

  // kind: 0 no strobe, 1 write, 2 read
  typedef struct {
    logic [1:0]  kind;
    logic [13:0] addr;
    logic [7:0]  data;
    logic [7:0]  rdata;
  } txn_t;

  txn_t exp_a[$];
  txn_t exp_b[$];
  int   ack_log[$];
  int   ack_cyc[$];
  int   n_checks = 0;
  int   n_err = 0;
  int   cycle = 0;

  logic        seen_strobe = 1'b0;
  logic [1:0]  s_kind;
  logic [13:0] s_addr;
  logic [7:0]  s_data;
  int          s_cycle;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, req, $time);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge busClk);
      #1;
    end
  endtask

  task automatic drive(input int m, input logic req, input logic [13:0] addr,
                       input logic [7:0] data, input logic w, input logic r);
    if (m == 0) begin
      reqA = req; addrA = addr; dataA = data; writeA = w; readA = r;
    end else begin
      reqB = req; addrB = addr; dataB = data; writeB = w; readB = r;
    end
  endtask

  task automatic expect_txn(input int m, input logic [1:0] kind, input logic [13:0] addr,
                            input logic [7:0] data, input logic [7:0] rdata);
    txn_t e;
    e.kind = kind; e.addr = addr; e.data = data; e.rdata = rdata;
    if (m == 0) exp_a.push_back(e);
    else        exp_b.push_back(e);
  endtask

  task automatic wait_ack(input int m, input int budget);
    bit got = 1'b0;
    for (int i = 0; i < budget && !got; i++) begin
      @(negedge busClk);
      got = (m == 0) ? ackA : ackB;
    end
    if (!got) begin
      n_checks++;
      n_err++;
      $display("FAIL ack_timeout: master %0d no ack within %0d cycles", m, budget);
    end
  endtask

  task automatic wait_strobe(input int budget);
    bit got = 1'b0;
    for (int i = 0; i < budget && !got; i++) begin
      @(negedge busClk);
      got = busWrite || busRead;
    end
    if (!got) begin
      n_checks++;
      n_err++;
      $display("FAIL strobe_timeout: no strobe within %0d cycles", budget);
    end
  endtask

  // m: 0 watch ackA, 1 watch ackB, 2 watch both
  task automatic expect_quiet(input int m, input int n, input string name);
    logic seen = 1'b0;
    repeat (n) begin
      @(negedge busClk);
      if ((m != 1 && ackA) || (m != 0 && ackB)) seen = 1'b1;
    end
    chk(name, seen, 0);
  endtask

  task automatic do_reset();
    busResetn = 1'b0;
    drive(0, 0, 14'h0, 8'h0, 0, 0);
    drive(1, 0, 14'h0, 8'h0, 0, 0);
    neoState = 1'b0;
    tick(2);
    busResetn = 1'b1;
    ack_log.delete();
    ack_cyc.delete();
  endtask

  task automatic check_ack(input int m, input logic [7:0] rd);
    txn_t e;
    bit   empty;
    empty = (m == 0) ? (exp_a.size() == 0) : (exp_b.size() == 0);
    if (empty) begin
      n_checks++;
      n_err++;
      $display("FAIL unexpected_ack: master %0d acked with nothing outstanding", m);
    end else begin
      if (m == 0) e = exp_a.pop_front();
      else        e = exp_b.pop_front();
      chk("ack_rdata", rd, e.rdata);
      if (e.kind == 2'd0) begin
        chk("no_strobe", seen_strobe, 0);
        chk("held_addr", busAddr, e.addr);
      end else begin
        chk("strobe_kind", seen_strobe ? s_kind : 2'd0, e.kind);
        chk("strobe_addr", s_addr, e.addr);
        if (e.kind == 2'd1) chk("strobe_data", s_data, e.data);
        chk("ack_latency", cycle - s_cycle, 1);
      end
      ack_log.push_back(m);
      ack_cyc.push_back(cycle);
    end
    seen_strobe = 1'b0;
  endtask

  // Bus model: read data appears the cycle after busRead, garbage otherwise.
  initial begin
    logic        rd_now;
    logic [13:0] rd_addr;
    busDataOut = 8'hEE;
    forever begin
      @(negedge busClk);
      rd_now  = busRead;
      rd_addr = busAddr;
      @(posedge busClk);
      #1;
      busDataOut = rd_now ? (rd_addr[7:0] ^ 8'h5F) : 8'hEE;
    end
  end

  // Monitor
  initial begin
    forever begin
      @(negedge busClk);
      cycle++;
      if (!busResetn) begin
        seen_strobe = 1'b0;
        continue;
      end
      if (busWrite || busRead) begin
        chk("strobe_exclusive", busWrite && busRead, 0);
        seen_strobe = 1'b1;
        s_kind  = busWrite ? 2'd1 : 2'd2;
        s_addr  = busAddr;
        s_data  = busDataIn;
        s_cycle = cycle;
      end
      if (ackA && ackB) chk("ack_exclusive", {ackA, ackB}, 0);
      if (ackA) check_ack(0, rdataA);
      if (ackB) check_ack(1, rdataB);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int exp_ord[4];
    exp_ord = '{0, 1, 0, 1};
    busResetn = 1'b0;
    neoState  = 1'b0;
    drive(0, 0, 14'h0, 8'h0, 0, 0);
    drive(1, 0, 14'h0, 8'h0, 0, 0);

    // 1: reset with A requesting, then A granted with busWrite on N+1
    drive(0, 1, 14'h2000, 8'h11, 1, 0);
    expect_txn(0, 2'd1, 14'h2000, 8'h11, 8'h00);
    tick(1);
    @(negedge busClk);
    chk("reset_bus", {busAddr, busDataIn, busWrite, busRead}, 0);
    chk("reset_master", {ackA, ackB, rdataA, rdataB}, 0);
    @(posedge busClk);
    #1;
    busResetn = 1'b1;
    @(negedge busClk);
    chk("idle_no_strobe", busWrite, 0);
    @(negedge busClk);
    chk("strobe_n1", busWrite, 1);
    wait_ack(0, 4);
    tick(1);
    reqA = 1'b0;

    // 2: both write continuously -> A,B,A,B every 3 cycles
    do_reset();
    drive(0, 1, 14'h2000, 8'hA1, 1, 0);
    drive(1, 1, 14'h2000, 8'hB1, 1, 0);
    expect_txn(0, 2'd1, 14'h2000, 8'hA1, 8'h00);
    expect_txn(1, 2'd1, 14'h2000, 8'hB1, 8'h00);
    fork
      begin
        wait_ack(0, 8);
        tick(1);
        drive(0, 1, 14'h2000, 8'hA2, 1, 0);
        expect_txn(0, 2'd1, 14'h2000, 8'hA2, 8'h00);
        wait_ack(0, 8);
        tick(1);
        reqA = 1'b0;
      end
      begin
        wait_ack(1, 8);
        tick(1);
        drive(1, 1, 14'h2000, 8'hB2, 1, 0);
        expect_txn(1, 2'd1, 14'h2000, 8'hB2, 8'h00);
        wait_ack(1, 8);
        tick(1);
        reqB = 1'b0;
      end
    join
    chk("rr_count", ack_log.size(), 4);
    for (int i = 0; i < 4 && i < ack_log.size(); i++) begin
      chk("rr_order", ack_log[i], exp_ord[i]);
      if (i > 0) chk("rr_spacing", ack_cyc[i] - ack_cyc[i-1], 3);
    end

    // 3: B read returns 0x5A; rdataB unchanged by a later A write
    do_reset();
    drive(1, 1, 14'h0005, 8'h00, 0, 1);
    expect_txn(1, 2'd2, 14'h0005, 8'h00, 8'h5A);
    wait_ack(1, 6);
    tick(1);
    reqB = 1'b0;
    drive(0, 1, 14'h2004, 8'h12, 1, 0);
    expect_txn(0, 2'd1, 14'h2004, 8'h12, 8'h00);
    wait_ack(0, 6);
    tick(1);
    reqA = 1'b0;
    @(negedge busClk);
    chk("rdataB_hold", rdataB, 8'h5A);

    // 4: pixel hold: A pixel write waits, B register read proceeds
    do_reset();
    neoState = 1'b1;
    drive(0, 1, 14'h0003, 8'h33, 1, 0);
    drive(1, 1, 14'h2001, 8'h00, 0, 1);
    expect_txn(0, 2'd1, 14'h0003, 8'h33, 8'h00);
    expect_txn(1, 2'd2, 14'h2001, 8'h00, 8'h5E);
    wait_ack(1, 6);
    tick(1);
    reqB = 1'b0;
    expect_quiet(0, 8, "hold_no_ackA");
    tick(1);
    neoState = 1'b0;
    wait_ack(0, 6);
    tick(1);
    reqA = 1'b0;

    // 5: reset during B's STROBE aborts it; rrPtr back to A
    do_reset();
    drive(0, 1, 14'h2000, 8'h00, 0, 1);
    expect_txn(0, 2'd2, 14'h2000, 8'h00, 8'h5F);
    wait_ack(0, 6);
    tick(1);
    reqA = 1'b0;
    drive(1, 1, 14'h2001, 8'h66, 1, 0);
    wait_strobe(6);
    busResetn = 1'b0;
    reqB = 1'b0;
    tick(1);
    @(negedge busClk);
    chk("abort_bus", {busAddr, busDataIn, busWrite, busRead}, 0);
    chk("abort_master", {ackA, ackB, rdataA, rdataB}, 0);
    tick(1);
    busResetn = 1'b1;
    expect_quiet(2, 4, "abort_no_ack");
    ack_log.delete();
    drive(0, 1, 14'h2002, 8'h01, 1, 0);
    drive(1, 1, 14'h2003, 8'h02, 1, 0);
    expect_txn(0, 2'd1, 14'h2002, 8'h01, 8'h00);
    expect_txn(1, 2'd1, 14'h2003, 8'h02, 8'h00);
    fork
      begin
        wait_ack(0, 8);
        tick(1);
        reqA = 1'b0;
      end
      begin
        wait_ack(1, 8);
        tick(1);
        reqB = 1'b0;
      end
    join
    chk("rr_reset_count", ack_log.size(), 2);
    if (ack_log.size() > 0) chk("rr_reset_first", ack_log[0], 0);

    // 6: write+read treated as write; neither gives no strobe and rdata 0
    do_reset();
    drive(0, 1, 14'h0010, 8'h77, 1, 1);
    expect_txn(0, 2'd1, 14'h0010, 8'h77, 8'h00);
    wait_ack(0, 6);
    tick(1);
    reqA = 1'b0;
    drive(0, 1, 14'h0011, 8'h78, 0, 0);
    expect_txn(0, 2'd0, 14'h0011, 8'h78, 8'h00);
    wait_ack(0, 6);
    tick(1);
    reqA = 1'b0;

    // 7: BUFFER_END is held, BUFFER_END+1 is not; neoState rise after grant is ignored
    do_reset();
    neoState = 1'b1;
    drive(0, 1, 14'h1FFF, 8'h43, 1, 0);
    expect_quiet(0, 6, "hold_boundary");
    tick(1);
    reqA = 1'b0;
    tick(1);
    drive(0, 1, 14'h2000, 8'h44, 1, 0);
    expect_txn(0, 2'd1, 14'h2000, 8'h44, 8'h00);
    wait_ack(0, 6);
    tick(1);
    reqA = 1'b0;
    neoState = 1'b0;
    drive(0, 1, 14'h0004, 8'h45, 1, 0);
    expect_txn(0, 2'd1, 14'h0004, 8'h45, 8'h00);
    wait_strobe(4);
    neoState = 1'b1;
    wait_ack(0, 4);
    tick(1);
    reqA = 1'b0;
    neoState = 1'b0;

    tick(3);
    chk("leftover_A", exp_a.size(), 0);
    chk("leftover_B", exp_b.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
